x_23k640_dispatch: RTL and testbench

- Front-end scheduler between the single application request/completion interface and the 8 per-chip x_23K640_data units in x_23K640_multiple.
- Decodes the bank from the address, steers each request to one unit, and tracks outstanding reads.
- Returns read completions to the application strictly in issue order, although banks may finish out of order.

---
 rtl/x_23k640_dispatch.sv | 151 +++++++++++++++
 tb/tb_x_23k640_dispatch.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/x_23k640_dispatch.sv
// rtl/x_23k640_dispatch.sv - in-order read dispatcher across per-chip 23K640 SRAM units
//
// Purpose:
//   Steers each application request to one bank. The bank is chosen by the address bits
//   above the chip address. The block tracks one outstanding read per bank and returns read
//   completions in issue order, even when banks finish out of order.
//
// Ports:
//   i_clk, i_rst          clock; synchronous active-low reset
//   i_valid/o_accept      application request handshake (taken when both high)
//   i_rd_n_wr             1 = read, 0 = write
//   i_addr, i_wdata       request address [bank|chip addr] and write data
//   o_ready/o_rdata       one-cycle in-order read completion
//   o_idle                no outstanding reads and no buffered data
//   o_err                 sticky: completion from a bank with no pending read
//   o_b_valid/i_b_accept  per-bank request handshake (o_b_valid one-hot or zero)
//   o_b_rd_n_wr, o_b_addr, o_b_wdata  broadcast request fields
//   i_b_ready/i_b_rdata   per-bank read completion strobe and data (bank b at [8b+7:8b])

module x_23k640_dispatch #(
    parameter int BANKS   = 8,
    parameter int BANK_AW = 13,
    parameter int DEPTH   = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_accept,
    input  logic                 i_rd_n_wr,
    input  logic [15:0]          i_addr,
    input  logic [7:0]           i_wdata,
    output logic                 o_ready,
    output logic [7:0]           o_rdata,
    output logic                 o_idle,
    output logic                 o_err,
    output logic [BANKS-1:0]     o_b_valid,
    input  logic [BANKS-1:0]     i_b_accept,
    output logic                 o_b_rd_n_wr,
    output logic [BANK_AW-1:0]   o_b_addr,
    output logic [7:0]           o_b_wdata,
    input  logic [BANKS-1:0]     i_b_ready,
    input  logic [8*BANKS-1:0]   i_b_rdata
);

    localparam int SW = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int PW = $clog2(DEPTH);

    // Order FIFO: holds the bank number of every accepted read, oldest at rd_ptr.
    // The pointers carry one extra wrap bit so that full and empty can be told apart.
    logic [SW-1:0]   ord_mem [DEPTH];
    logic [PW:0]     wr_ptr;
    logic [PW:0]     rd_ptr;
    logic            fifo_empty;
    logic            fifo_full;
    logic [SW-1:0]   head;

    // Per-bank state: read outstanding, and completion data captured but not yet returned
    logic [BANKS-1:0] pend;
    logic [BANKS-1:0] buf_v;
    logic [7:0]       rbuf [BANKS];

    logic [SW-1:0]   sel;
    logic            block;
    logic            push;
    logic            pop;

    assign sel        = i_addr[BANK_AW +: SW];
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                        (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head       = ord_mem[rd_ptr[PW-1:0]];

    // A read waits while its bank already has a read in flight or the order FIFO is full.
    // Writes are never held here; the bank serialises them behind its own pending read.
    assign block = i_rd_n_wr && (pend[sel] || fifo_full);

    // o_accept does not look at i_valid, so no application-side combinational loop is
    // formed. Both handshake outputs are forced low while reset is held.
    assign o_accept = i_rst && i_b_accept[sel] && !block;

    always_comb begin
        o_b_valid = '0;
        if (i_rst && i_valid && !block) begin
            o_b_valid[sel] = 1'b1;
        end
    end

    assign o_b_rd_n_wr = i_rd_n_wr;
    assign o_b_addr    = i_addr[BANK_AW-1:0];
    assign o_b_wdata   = i_wdata;

    assign push = i_valid && o_accept && i_rd_n_wr;
    // A completion can be returned only once the oldest outstanding read has its data
    assign pop  = !fifo_empty && buf_v[head];

    assign o_idle = fifo_empty && (pend == '0);

    // Storage arrays need no reset; their valid state lives in buf_v and the pointers.
    always_ff @(posedge i_clk) begin
        if (push) begin
            ord_mem[wr_ptr[PW-1:0]] <= sel;
        end
        for (int b = 0; b < BANKS; b++) begin
            if (i_b_ready[b] && pend[b]) begin
                rbuf[b] <= i_b_rdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pend    <= '0;
            buf_v   <= '0;
            o_ready <= 1'b0;
            o_rdata <= 8'h00;
            o_err   <= 1'b0;
        end else begin
            // Capture completions. A strobe from a bank with nothing pending is a
            // protocol error: its data is dropped and the sticky error is raised.
            for (int b = 0; b < BANKS; b++) begin
                if (i_b_ready[b]) begin
                    if (pend[b]) begin
                        buf_v[b] <= 1'b1;
                    end else begin
                        o_err <= 1'b1;
                    end
                end
            end

            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                pend[sel] <= 1'b1;
            end

            // A push can never target the bank being popped, because pend[head] still
            // blocks that read. The two updates therefore never touch the same bit.
            if (pop) begin
                o_ready     <= 1'b1;
                o_rdata     <= rbuf[head];
                rd_ptr      <= rd_ptr + 1'b1;
                buf_v[head] <= 1'b0;
                pend[head]  <= 1'b0;
            end else begin
                o_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_x_23k640_dispatch.sv
// tb/tb_x_23k640_dispatch.sv - scoreboard bench for x_23k640_dispatch (DEPTH=4)

module tb_x_23k640_dispatch;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        accept;
    logic        rd_n_wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        ready;
    logic [7:0]  rdata;
    logic        idle;
    logic        err;
    logic [7:0]  b_valid;
    logic [7:0]  b_accept;
    logic        b_rd_n_wr;
    logic [12:0] b_addr;
    logic [7:0]  b_wdata;
    logic [7:0]  b_ready;
    logic [63:0] b_rdata;

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] exp_q[$];
    bit done = 0;

    x_23k640_dispatch #(.BANKS(8), .BANK_AW(13), .DEPTH(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_accept(accept),
        .i_rd_n_wr(rd_n_wr), .i_addr(addr), .i_wdata(wdata),
        .o_ready(ready), .o_rdata(rdata), .o_idle(idle), .o_err(err),
        .o_b_valid(b_valid), .i_b_accept(b_accept), .o_b_rd_n_wr(b_rd_n_wr),
        .o_b_addr(b_addr), .o_b_wdata(b_wdata), .i_b_ready(b_ready), .i_b_rdata(b_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse one bank's completion strobe for a single cycle
    task automatic bank_done(input int b, input logic [7:0] d);
        b_ready = 8'h00;
        b_ready[b] = 1'b1;
        b_rdata = 64'h0;
        b_rdata[8*b +: 8] = d;
        tick();
        b_ready = 8'h00;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && idle) break;
            tick();
        end
        chk(name, {63'h0, (exp_q.size() == 0 && idle)}, 64'h1);
    endtask

    // Monitor: every completion strobe must match the oldest expected read data
    initial begin
        logic [7:0] e;
        while (!done) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_o_ready", {56'h0, rdata}, 64'hx);
                end else begin
                    e = exp_q.pop_front();
                    chk("rdata_order", {56'h0, rdata}, {56'h0, e});
                end
            end
        end
    end

    initial begin
        rst = 1'b0; valid = 1'b1; rd_n_wr = 1'b1; addr = 16'h0000; wdata = 8'h00;
        b_accept = 8'hFF; b_ready = 8'h00; b_rdata = 64'h0;

        // Reset holds the request path closed even with i_valid high
        tick(); tick();
        chk("rst_b_valid", {56'h0, b_valid}, 64'h0);
        chk("rst_accept", {63'h0, accept}, 64'h0);
        valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("idle_after_rst", {63'h0, idle}, 64'h1);
        chk("ready_after_rst", {63'h0, ready}, 64'h0);
        chk("err_after_rst", {63'h0, err}, 64'h0);
        chk("b_valid_idle", {56'h0, b_valid}, 64'h0);

        // Write to bank 2: broadcast fields, one-hot valid, no completion
        valid = 1'b1; rd_n_wr = 1'b0; addr = 16'h4123; wdata = 8'hA5;
        #1;
        chk("wr_b_valid", {56'h0, b_valid}, 64'h04);
        chk("wr_b_addr", {51'h0, b_addr}, 64'h0123);
        chk("wr_b_wdata", {56'h0, b_wdata}, 64'hA5);
        chk("wr_b_rd_n_wr", {63'h0, b_rd_n_wr}, 64'h0);
        chk("wr_accept", {63'h0, accept}, 64'h1);
        tick();
        valid = 1'b0;
        repeat (4) tick();
        chk("wr_idle", {63'h0, idle}, 64'h1);

        // Two reads; bank 7 finishes first, yet bank 0 data must come out first
        valid = 1'b1; rd_n_wr = 1'b1; addr = 16'h0010;
        #1;
        chk("rd0_b_valid", {56'h0, b_valid}, 64'h01);
        chk("rd0_accept", {63'h0, accept}, 64'h1);
        tick(); exp_q.push_back(8'h11);
        addr = 16'hE010;
        #1;
        chk("rd7_b_valid", {56'h0, b_valid}, 64'h80);
        tick(); exp_q.push_back(8'h77);
        valid = 1'b0;
        chk("rd_not_idle", {63'h0, idle}, 64'h0);
        bank_done(7, 8'h77);
        repeat (3) tick();
        bank_done(0, 8'h11);
        wait_drain("ooo_drain");

        // Second read to the same bank is held until the first completion is popped
        valid = 1'b1; addr = 16'h2000;
        tick(); exp_q.push_back(8'h5A);
        addr = 16'h2001;
        #1;
        chk("same_bank_block_acc", {63'h0, accept}, 64'h0);
        chk("same_bank_block_bv", {56'h0, b_valid}, 64'h0);
        tick();
        chk("same_bank_hold", {63'h0, accept}, 64'h0);
        bank_done(1, 8'h5A);
        chk("same_bank_n1", {63'h0, accept}, 64'h0);
        tick();
        chk("latency_o_ready", {63'h0, ready}, 64'h1);
        chk("same_bank_release", {63'h0, accept}, 64'h1);
        chk("same_bank_release_bv", {56'h0, b_valid}, 64'h02);
        tick(); exp_q.push_back(8'h5B);
        valid = 1'b0;
        bank_done(1, 8'h5B);
        wait_drain("same_bank_drain");

        // Eight reads against a 4-deep order FIFO
        valid = 1'b1;
        for (int b = 0; b < 8; b++) begin
            addr = {b[2:0], 13'h0040};
            #1;
            if (b >= 4) begin
                chk($sformatf("full_stall_%0d", b), {63'h0, accept}, 64'h0);
                bank_done(b - 4, 8'h30 + 8'(b - 4));
                chk($sformatf("full_stall_n1_%0d", b), {63'h0, accept}, 64'h0);
                tick();
            end
            chk($sformatf("fill_accept_%0d", b), {63'h0, accept}, 64'h1);
            tick(); exp_q.push_back(8'h30 + 8'(b));
        end
        valid = 1'b0;
        for (int b = 7; b >= 4; b--) bank_done(b, 8'h30 + 8'(b));
        wait_drain("fill_drain");

        // Completion from a bank with nothing pending
        bank_done(3, 8'hEE);
        tick();
        chk("err_set", {63'h0, err}, 64'h1);
        repeat (3) tick();
        chk("err_sticky", {63'h0, err}, 64'h1);
        rst = 1'b0; tick(); rst = 1'b1; tick();
        chk("err_cleared", {63'h0, err}, 64'h0);

        // Reset with three reads outstanding; late completions are errors only
        valid = 1'b1;
        addr = 16'h4000; tick();
        addr = 16'hA000; tick();
        addr = 16'hC000; tick();
        valid = 1'b0;
        chk("three_outstanding", {63'h0, idle}, 64'h0);
        rst = 1'b0; tick(); rst = 1'b1;
        chk("rst_mid_idle", {63'h0, idle}, 64'h1);
        chk("rst_mid_err", {63'h0, err}, 64'h0);
        b_ready = 8'h64; b_rdata = 64'h0066_5500_0044_0000;
        tick();
        b_ready = 8'h00;
        tick();
        chk("late_err", {63'h0, err}, 64'h1);
        repeat (4) tick();
        chk("late_idle", {63'h0, idle}, 64'h1);
        chk("queue_empty", {32'h0, 32'(exp_q.size())}, 64'h0);

        done = 1;
        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
